// File: rtl/sweep_voice_pkg.sv
// Shared types and constants for the sweep_voice audio generator.
// Holds the voice mode encoding and the noise LFSR polynomial/seed.
package sweep_voice_pkg;

  typedef enum logic [1:0] {
    MODE_TONE       = 2'd0,
    MODE_SWEEP_UP   = 2'd1,
    MODE_SWEEP_DOWN = 2'd2,
    MODE_NOISE      = 2'd3
  } mode_e;

  localparam int LFSR_W = 15;

  // x^15 + x^14 + 1: feedback from state bits 14 and 13
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

endpackage

// File: rtl/sweep_voice_if.sv
// Config valid/ready bundle for sweep_voice.
// master drives the i_Cfg_* offer, slave returns o_Cfg_Ready.
interface sweep_voice_if #(
  parameter int CNT_W = 16,
  parameter int VOL_W = 3
);

  logic             i_Cfg_Valid;
  logic             o_Cfg_Ready;
  logic [1:0]       i_Cfg_Mode;
  logic [CNT_W-1:0] i_Cfg_Period;
  logic [CNT_W-1:0] i_Cfg_Step;
  logic [CNT_W-1:0] i_Cfg_Limit;
  logic [VOL_W-1:0] i_Cfg_Volume;

  modport master (
    output i_Cfg_Valid,
    output i_Cfg_Mode,
    output i_Cfg_Period,
    output i_Cfg_Step,
    output i_Cfg_Limit,
    output i_Cfg_Volume,
    input  o_Cfg_Ready
  );

  modport slave (
    input  i_Cfg_Valid,
    input  i_Cfg_Mode,
    input  i_Cfg_Period,
    input  i_Cfg_Step,
    input  i_Cfg_Limit,
    input  i_Cfg_Volume,
    output o_Cfg_Ready
  );

endinterface

// File: rtl/sweep_voice_lfsr_step.sv
// Fibonacci LFSR for the noise voice; advances on i_Adv.
// Ports: i_Clk, i_Reset_n, i_Adv strobe, o_Bit = next feedback bit.
module lfsr_step
  import sweep_voice_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Adv,
  output logic o_Bit
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] nxt;
  logic              fb;

  always_comb begin
    fb  = ^(state & LFSR_TAPS);
    nxt = {state[LFSR_W-2:0], fb};
  end

  // o_Bit is the bit that becomes state[0] on this advance
  assign o_Bit = fb;

  // reseed guard keeps the register out of the all-zero lockup
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= LFSR_SEED;
    end else if (i_Adv) begin
      state <= (nxt == '0) ? LFSR_SEED : nxt;
    end
  end

endmodule

// File: rtl/sweep_voice.sv
// Single audio voice: PWM-gated tone, up/down sweep or LFSR noise.
// Ports: i_Clk, i_Reset_n, i_Enable, cfg (slave), o_Out, o_Phase, o_Sweep_Done.
module sweep_voice
  import sweep_voice_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int VOL_W = 3
) (
  input  logic         i_Clk,
  input  logic         i_Reset_n,
  input  logic         i_Enable,
  sweep_voice_if.slave cfg,
  output logic         o_Out,
  output logic         o_Phase,
  output logic         o_Sweep_Done
);

  localparam int TW = CNT_W + VOL_W + 1;

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             pending;
  logic             done_seen;

  mode_e            mode;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] limit;
  logic [VOL_W-1:0] volume;

  mode_e            sh_mode;
  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_step;
  logic [CNT_W-1:0] sh_limit;
  logic [VOL_W-1:0] sh_volume;

  logic             term;
  logic             xfer;
  logic             apply;
  logic             is_sweep;
  logic             lfsr_adv;
  logic             lfsr_bit;
  mode_e            eff_mode;
  logic [CNT_W:0]   sum_up;
  logic [CNT_W:0]   lim_up;
  logic [CNT_W-1:0] swept;
  logic [TW-1:0]    prod;
  logic [TW-1:0]    thresh;
  logic             cnt_lt;

  assign cfg.o_Cfg_Ready = ~pending;

  always_comb begin
    term     = i_Enable && (cnt == period);
    xfer     = cfg.i_Cfg_Valid && !pending;
    // shadow lands on an event, or straight away while stopped
    apply    = pending && (term || !i_Enable);
    eff_mode = apply ? sh_mode : mode;
    lfsr_adv = term && (eff_mode == MODE_NOISE);
    is_sweep = (mode == MODE_SWEEP_UP) ||
               (mode == MODE_SWEEP_DOWN);
  end

  // one-bit-wider sums so the limit compare cannot wrap
  always_comb begin
    sum_up = {1'b0, period} + {1'b0, step};
    lim_up = {1'b0, limit} + {1'b0, step};
    swept  = period;
    unique case (1'b1)
      mode == MODE_SWEEP_UP: begin
        if (sum_up >= {1'b0, limit}) swept = limit;
        else                         swept = sum_up[CNT_W-1:0];
      end
      mode == MODE_SWEEP_DOWN: begin
        if ({1'b0, period} < lim_up) swept = limit;
        else                         swept = period - step;
      end
      default: swept = period;
    endcase
  end

  // high-half duty threshold: (period+1)*volume / 2^VOL_W
  always_comb begin
    prod   = ({{(VOL_W+1){1'b0}}, period} + TW'(1)) *
             {{(CNT_W+1){1'b0}}, volume};
    thresh = prod >> VOL_W;
    cnt_lt = {{(VOL_W+1){1'b0}}, cnt} < thresh;
  end

  lfsr_step u_lfsr (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Adv     (lfsr_adv),
    .o_Bit     (lfsr_bit)
  );

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt          <= '0;
      phase        <= 1'b0;
      pending      <= 1'b0;
      done_seen    <= 1'b0;
      mode         <= MODE_TONE;
      period       <= '1;
      step         <= '0;
      limit        <= '0;
      volume       <= '0;
      sh_mode      <= MODE_TONE;
      sh_period    <= '0;
      sh_step      <= '0;
      sh_limit     <= '0;
      sh_volume    <= '0;
      o_Out        <= 1'b0;
      o_Phase      <= 1'b0;
      o_Sweep_Done <= 1'b0;
    end else begin
      o_Phase      <= phase;
      o_Sweep_Done <= 1'b0;

      if (xfer) begin
        sh_mode   <= mode_e'(cfg.i_Cfg_Mode);
        sh_period <= cfg.i_Cfg_Period;
        sh_step   <= cfg.i_Cfg_Step;
        sh_limit  <= cfg.i_Cfg_Limit;
        sh_volume <= cfg.i_Cfg_Volume;
        pending   <= 1'b1;
      end

      if (apply) begin
        mode      <= sh_mode;
        period    <= sh_period;
        step      <= sh_step;
        limit     <= sh_limit;
        volume    <= sh_volume;
        done_seen <= 1'b0;
        pending   <= 1'b0;
      end

      if (!i_Enable) begin
        cnt   <= '0;
        phase <= 1'b0;
        o_Out <= 1'b0;
      end else begin
        o_Out <= phase & cnt_lt;
        if (term) begin
          cnt <= '0;
          if (eff_mode == MODE_NOISE) phase <= lfsr_bit;
          else                        phase <= ~phase;
          // an applying event takes the new period as-is
          if (!apply && is_sweep) begin
            period <= swept;
            if ((swept == limit) && !done_seen) begin
              o_Sweep_Done <= 1'b1;
              done_seen    <= 1'b1;
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
